spi_arb: RTL and testbench
==========================

// Module: spi_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one SPI_mstr16 between N_REQ requesters (inert_intf-style sensor FSMs, A2D_intf).
//  Latches the winner's 16-bit cmd, launches one master transaction and routes the master SS_n to that requester's chip select.
//  Returns rd_data with a per-requester done pulse, then enforces an inter-frame gap. A per-transaction watchdog flags a hung master.
// PARAMETERS
//  N_REQ        2     number of requesters (>=2); owner index width OW = $clog2(N_REQ)
//  GAP_CYC      2     clocks all ss_n held high after a transaction before next grant (>=1)
//  TIMEOUT_CYC  4096  clocks to wait for mstr_done after launch before abort
// PORTS
//  clk        in   1         system clock; all logic on posedge
//  rst        in   1         synchronous, active-high reset
//  req        in   N_REQ     per-requester level request; sampled only in IDLE
//  cmd_in     in   16*N_REQ  flat cmd vector, slice i = cmd_in[16*i+:16]; must be stable while req[i]=1
//  gnt        out  N_REQ     one-hot 1-clk pulse: cmd of that requester latched this cycle
//  done       out  N_REQ     one-hot 1-clk pulse: owner's transaction complete, rd_data valid
//  err        out  N_REQ     one-hot 1-clk pulse: owner's transaction timed out
//  rd_data    out  16        last completed read data, held until next completion
//  busy       out  1         1 in every state except IDLE
//  ss_n       out  N_REQ     per-requester chip selects to sensors
//  mstr_wrt   out  1         to SPI_mstr16 wrt
//  mstr_cmd   out  16        to SPI_mstr16 cmd (registered)
//  mstr_done  in   1         from SPI_mstr16 done
//  mstr_rd    in   16        from SPI_mstr16 rd_data
//  mstr_ss_n  in   1         from SPI_mstr16 SS_n
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, owner=0; gnt/done/err/mstr_wrt=0, mstr_cmd=0, rd_data=0, busy=0, all ss_n=1.
//  FSM:
//   IDLE:   if |req: winner = first set req scanning ptr, ptr+1, ... mod N_REQ; owner<=winner,
//           mstr_cmd<=cmd_in slice, gnt[winner]=1 -> LAUNCH. Else stay.
//   LAUNCH: mstr_wrt=1 for exactly this clk; clear watchdog -> BUSY.
//   BUSY:   on mstr_done: rd_data<=mstr_rd, done[owner]=1, ptr<=(owner+1)%N_REQ -> GAP.
//           Else if watchdog==TIMEOUT_CYC-1: err[owner]=1, rd_data unchanged, ptr<=(owner+1)%N_REQ -> GAP.
//   GAP:    count GAP_CYC clks -> IDLE.
//  Latency: gnt at IDLE cycle T; mstr_wrt at T+1; done in the clk mstr_done seen; next gnt >= done + GAP_CYC + 1.
//  ss_n[i] = (state in {LAUNCH,BUSY} && owner==i) ? mstr_ss_n : 1. Never >1 ss_n low; all high in IDLE/GAP.
//  Handshake: req sampled only in IDLE. Requester keeps req/cmd stable until gnt, then may drop req.
//   req still high when arbiter re-enters IDLE = new request.
//  Simultaneous reqs: pointer priority; after reset, requester 0 wins first.
//   req arriving during BUSY/GAP waits; req dropped before IDLE is lost, no error.
//  mstr_done outside BUSY: ignored. done and err never in same clk.
//  Reset mid-transaction: next edge forces reset state, ss_n all high. mstr_ss_n is not honoured after reset.
//   SPI_mstr16 must be reset in the same clk (top ties its rst_n = ~rst).
//  Watchdog: counter sized $clog2(TIMEOUT_CYC), saturates, cleared in LAUNCH.
// STRUCTURE
//  spi_arb_pkg: state_t enum {IDLE,LAUNCH,BUSY,GAP}; SPI_CMD_W=16; SPI_RD_W=16.
//  Sub-module rr_arbiter: req[N_REQ], ptr[OW] -> one-hot gnt_vec, any, idx[OW]; purely combinational.
//  Remaining logic (FSM, gap/watchdog counters, output regs, ss_n mux) lives in spi_arb.
// TESTING (bench models SPI_mstr16: done 40 clks after wrt, ss_n low in between)
//  Single req[0], cmd0=16'hA200, model rd=16'h00A5:
//   gnt[0] 1 clk, mstr_wrt next clk with mstr_cmd=A200, done[0] pulse, rd_data=00A5, ss_n[1] stays 1.
//  req=2'b11 held from reset: grants alternate 0,1,0,1. Each gap between done and next gnt is GAP_CYC+1 clks.
//  Model never returns done, TIMEOUT_CYC=64: err[owner] pulse 64 clks after launch, ss_n all 1, next req served.
//  req[1] raised mid-BUSY of requester 0, dropped after 10 clks: no gnt[1], arbiter returns to IDLE.
//  rst asserted 5 clks into BUSY: next clk busy=0, ss_n=2'b11, ptr=0; stale mstr_done ignored.
//  mstr_done pulsed in IDLE: no done/err pulses, rd_data unchanged.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI master arbiter/sequencer.
package spi_arb_pkg;

   localparam int unsigned SPI_CMD_W = 16;
   localparam int unsigned SPI_RD_W  = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      GAP    = 2'd3
   } state_t;

endpackage : spi_arb_pkg

// File: rtl/spi_arb_rr_arbiter.sv
// Round-robin request picker (purely combinational).
// Scans req starting at ptr, wrapping modulo N_REQ, and returns the first set
// request as a one-hot vector plus its index.
//   req     in   N_REQ  request levels
//   ptr     in   OW     index with highest priority this round
//   gnt_vec out  N_REQ  one-hot winner (all zero if no request)
//   any     out  1      at least one request present
//   idx     out  OW     index of the winner (0 if none)
module spi_arb_rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned OW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [OW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt_vec,
   output logic             any,
   output logic [OW-1:0]    idx
);

   logic [OW-1:0] cand;

   // First set request at ptr, ptr+1, ... (mod N_REQ) wins.
   always_comb begin
      gnt_vec = '0;
      any     = 1'b0;
      idx     = '0;
      cand    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = OW'((32'(ptr) + i) % N_REQ);
         if (!any && req[cand]) begin
            any           = 1'b1;
            idx           = cand;
            gnt_vec[cand] = 1'b1;
         end
      end
   end

endmodule : spi_arb_rr_arbiter

// File: rtl/spi_arb.sv
// Round-robin arbiter/sequencer sharing one 16-bit SPI master among N_REQ
// requesters. Latches the winner's command, launches one master transaction,
// routes the master chip select to the owner, returns read data with a done
// pulse, enforces an inter-frame gap and aborts hung transactions.
//   clk, rst        clock, synchronous active-high reset
//   req, cmd_in     per-requester request level and 16-bit command slice
//   gnt, done, err  one-hot 1-clk pulses: granted / completed / timed out
//   rd_data         last completed read data (held)
//   busy            high in every state but IDLE
//   ss_n            per-requester chip selects
//   mstr_*          connection to the shared SPI master
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int unsigned N_REQ       = 2,
   parameter int unsigned GAP_CYC     = 2,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [SPI_CMD_W*N_REQ-1:0] cmd_in,
   output logic [N_REQ-1:0]           gnt,
   output logic [N_REQ-1:0]           done,
   output logic [N_REQ-1:0]           err,
   output logic [SPI_RD_W-1:0]        rd_data,
   output logic                       busy,
   output logic [N_REQ-1:0]           ss_n,
   output logic                       mstr_wrt,
   output logic [SPI_CMD_W-1:0]       mstr_cmd,
   input  logic                       mstr_done,
   input  logic [SPI_RD_W-1:0]        mstr_rd,
   input  logic                       mstr_ss_n
);

   localparam int unsigned OW = $clog2(N_REQ);
   localparam int unsigned GW = $clog2(GAP_CYC + 1);
   localparam int unsigned WW = $clog2(TIMEOUT_CYC);

   localparam logic [OW-1:0] OWNER_LAST = OW'(N_REQ - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
   localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYC - 1);

   state_t            state;
   state_t            state_nxt;
   logic [OW-1:0]     ptr;
   logic [OW-1:0]     owner;
   logic [OW-1:0]     ptr_after_owner;
   logic [GW-1:0]     gap_cnt;
   logic [WW-1:0]     wd_cnt;
   logic              wd_expired;

   logic [N_REQ-1:0]  arb_gnt;
   logic              arb_any;
   logic [OW-1:0]     arb_idx;

   spi_arb_rr_arbiter #(
      .N_REQ (N_REQ),
      .OW    (OW)
   ) u_rr (
      .req     (req),
      .ptr     (ptr),
      .gnt_vec (arb_gnt),
      .any     (arb_any),
      .idx     (arb_idx)
   );

   assign ptr_after_owner = (owner == OWNER_LAST) ? '0 : owner + OW'(1);
   assign wd_expired      = (wd_cnt == WD_LAST);
   assign busy            = (state != IDLE);

   // Next state and per-cycle pulses; pulses are suppressed while in reset.
   always_comb begin
      state_nxt = state;
      gnt       = '0;
      done      = '0;
      err       = '0;
      mstr_wrt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (arb_any) begin
               gnt       = arb_gnt;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            mstr_wrt  = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: begin
            // Completion takes precedence so done and err never coincide.
            if (mstr_done) begin
               done[owner] = 1'b1;
               state_nxt   = GAP;
            end else if (wd_expired) begin
               err[owner] = 1'b1;
               state_nxt  = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) begin
         gnt      = '0;
         done     = '0;
         err      = '0;
         mstr_wrt = 1'b0;
      end
   end

   // State register, owner/command capture, counters and read-data hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         mstr_cmd <= '0;
         rd_data  <= '0;
         gap_cnt  <= '0;
         wd_cnt   <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (arb_any) begin
                  owner    <= arb_idx;
                  mstr_cmd <= cmd_in[SPI_CMD_W*32'(arb_idx) +: SPI_CMD_W];
               end
            end
            LAUNCH: begin
               wd_cnt  <= '0;
               gap_cnt <= '0;
            end
            BUSY: begin
               if (mstr_done) begin
                  rd_data <= mstr_rd;
                  ptr     <= ptr_after_owner;
               end else if (wd_expired) begin
                  ptr <= ptr_after_owner;
               end else if (wd_cnt != '1) begin
                  wd_cnt <= wd_cnt + WW'(1);
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + GW'(1);
            end
            default: ;
         endcase
      end
   end

   // Only the owner sees the master chip select, and only mid-transaction.
   always_comb begin
      ss_n = '1;
      if (state == LAUNCH || state == BUSY) begin
         ss_n[owner] = mstr_ss_n;
      end
   end

endmodule : spi_arb

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb with a behavioural SPI master
// (done 40 clocks after wrt, chip select low in between).
module tb_spi_arb;
   import spi_arb_pkg::*;

   localparam int unsigned N   = 2;
   localparam int unsigned GAP = 2;
   localparam int unsigned TO  = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [31:0] cmd_in;
   logic [1:0]  gnt, done, err, ss_n;
   logic [15:0] rd_data, mstr_cmd, mstr_rd;
   logic        busy, mstr_wrt, mstr_done, mstr_ss_n;

   logic        model_hang, model_clr, force_done;
   logic [15:0] model_rd;
   logic        m_busy, m_done, m_ss;
   int          m_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int both_low_cnt = 0;
   int ss1_low_cnt = 0;
   int gnt1_cnt = 0;

   always #5 clk = ~clk;

   spi_arb #(.N_REQ(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .cmd_in(cmd_in),
      .gnt(gnt), .done(done), .err(err), .rd_data(rd_data), .busy(busy),
      .ss_n(ss_n), .mstr_wrt(mstr_wrt), .mstr_cmd(mstr_cmd),
      .mstr_done(mstr_done), .mstr_rd(mstr_rd), .mstr_ss_n(mstr_ss_n)
   );

   assign mstr_done = m_done | force_done;
   assign mstr_ss_n = m_ss;
   assign mstr_rd   = model_rd;

   // SPI master model.
   always @(posedge clk) begin
      if (rst || model_clr) begin
         m_busy <= 1'b0; m_cnt <= 0; m_done <= 1'b0; m_ss <= 1'b1;
      end else begin
         m_done <= 1'b0;
         if (mstr_wrt) begin
            m_busy <= 1'b1; m_cnt <= 1; m_ss <= 1'b0;
         end else if (m_busy) begin
            if (m_done) begin
               m_busy <= 1'b0; m_ss <= 1'b1;
            end else if (!model_hang && m_cnt == 39) begin
               m_done <= 1'b1;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ss_n == 2'b00) both_low_cnt <= both_low_cnt + 1;
      if (!ss_n[1])      ss1_low_cnt  <= ss1_low_cnt + 1;
      if (gnt[1])        gnt1_cnt     <= gnt1_cnt + 1;
   end

   // Waits (bounded) for sel: 0=any gnt, 1=any done, 2=any err; returns at that negedge.
   task automatic wait_sig(input int sel, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < max_cyc; n++) begin
         @(negedge clk);
         if ((sel == 0 && gnt != 2'b00) || (sel == 1 && done != 2'b00) ||
             (sel == 2 && err != 2'b00)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 2'b00; cmd_in = '0;
      model_hang = 1'b0; model_clr = 1'b0; force_done = 1'b0; model_rd = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({gnt, done, err, mstr_wrt, busy} !== 8'h00) begin
         n_fail++; $display("FAIL reset_pulses: got %b, expected 00000000", {gnt, done, err, mstr_wrt, busy});
      end
      n_tests++;
      if (mstr_cmd !== 16'h0000 || rd_data !== 16'h0000) begin
         n_fail++; $display("FAIL reset_regs: got cmd=%h rd=%h, expected 0000 0000", mstr_cmd, rd_data);
      end
      n_tests++;
      if (ss_n !== 2'b11) begin
         n_fail++; $display("FAIL reset_ss_n: got %b, expected 11", ss_n);
      end
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok; int t_g, t_d, s1;
      s1 = ss1_low_cnt;
      cmd_in = {16'h1234, 16'hA200}; model_rd = 16'h00A5;
      @(posedge clk); #1; req = 2'b01;
      wait_sig(0, 20, ok); t_g = cyc;
      n_tests++;
      if (!ok || gnt !== 2'b01) begin
         n_fail++; $display("FAIL single_gnt: got %b (seen=%0d), expected 01", gnt, ok);
      end
      @(posedge clk); #1; req = 2'b00;
      @(negedge clk);
      n_tests++;
      if (mstr_wrt !== 1'b1 || gnt !== 2'b00 || mstr_cmd !== 16'hA200) begin
         n_fail++; $display("FAIL single_launch: got wrt=%b gnt=%b cmd=%h, expected 1 00 a200", mstr_wrt, gnt, mstr_cmd);
      end
      @(negedge clk);
      n_tests++;
      if (mstr_wrt !== 1'b0 || ss_n !== 2'b10) begin
         n_fail++; $display("FAIL single_busy: got wrt=%b ss_n=%b, expected 0 10", mstr_wrt, ss_n);
      end
      wait_sig(1, 100, ok); t_d = cyc;
      n_tests++;
      if (!ok || done !== 2'b01 || err !== 2'b00) begin
         n_fail++; $display("FAIL single_done: got done=%b err=%b, expected 01 00", done, err);
      end
      n_tests++;
      if (t_d - t_g != 41) begin
         n_fail++; $display("FAIL single_latency: got %0d, expected 41", t_d - t_g);
      end
      @(negedge clk);
      n_tests++;
      if (rd_data !== 16'h00A5 || ss_n !== 2'b11 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_rd: got rd=%h ss_n=%b busy=%b, expected 00a5 11 1", rd_data, ss_n, busy);
      end
      repeat (2) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || ss1_low_cnt != s1) begin
         n_fail++; $display("FAIL single_idle: got busy=%b ss1_low=%0d, expected 0 0", busy, ss1_low_cnt - s1);
      end
   endtask

   task automatic test_alternate();
      bit ok; int t_d; logic [1:0] exp_g; logic [15:0] exp_c;
      t_d = 0;
      @(posedge clk); #1; rst = 1'b1; req = 2'b11; cmd_in = {16'h2222, 16'h1111};
      repeat (2) @(posedge clk); #1; rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_c = (k % 2 == 0) ? 16'h1111 : 16'h2222;
         model_rd = 16'h1000 + 16'(k);
         wait_sig(0, 200, ok);
         n_tests++;
         if (!ok || gnt !== exp_g) begin
            n_fail++; $display("FAIL alt_gnt%0d: got %b, expected %b", k, gnt, exp_g);
         end
         if (k > 0) begin
            n_tests++;
            if (cyc - t_d != 3) begin
               n_fail++; $display("FAIL alt_gap%0d: got %0d, expected 3", k, cyc - t_d);
            end
         end
         @(negedge clk);
         n_tests++;
         if (mstr_cmd !== exp_c) begin
            n_fail++; $display("FAIL alt_cmd%0d: got %h, expected %h", k, mstr_cmd, exp_c);
         end
         wait_sig(1, 200, ok); t_d = cyc;
         n_tests++;
         if (!ok || done !== exp_g) begin
            n_fail++; $display("FAIL alt_done%0d: got %b, expected %b", k, done, exp_g);
         end
         if (k == 3) begin
            @(posedge clk); #1; req = 2'b00;
         end
         @(negedge clk);
         n_tests++;
         if (rd_data !== 16'h1000 + 16'(k)) begin
            n_fail++; $display("FAIL alt_rd%0d: got %h, expected %h", k, rd_data, 16'h1000 + 16'(k));
         end
      end
      repeat (4) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL alt_idle: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_timeout();
      bit ok; int t_g;
      model_hang = 1'b1;
      @(posedge clk); #1; req = 2'b10;
      wait_sig(0, 20, ok); t_g = cyc;
      n_tests++;
      if (!ok || gnt !== 2'b10) begin
         n_fail++; $display("FAIL to_gnt: got %b, expected 10", gnt);
      end
      @(posedge clk); #1; req = 2'b00;
      wait_sig(2, 200, ok);
      n_tests++;
      if (!ok || err !== 2'b10 || done !== 2'b00) begin
         n_fail++; $display("FAIL to_err: got err=%b done=%b, expected 10 00", err, done);
      end
      n_tests++;
      if (cyc - t_g != 65) begin
         n_fail++; $display("FAIL to_latency: got %0d, expected 65", cyc - t_g);
      end
      @(negedge clk);
      n_tests++;
      if (ss_n !== 2'b11 || err !== 2'b00 || rd_data !== 16'h1003) begin
         n_fail++; $display("FAIL to_after: got ss_n=%b err=%b rd=%h, expected 11 00 1003", ss_n, err, rd_data);
      end
      @(posedge clk); #1; model_hang = 1'b0; model_clr = 1'b1;
      @(posedge clk); #1; model_clr = 1'b0; model_rd = 16'h5A5A; req = 2'b01;
      wait_sig(0, 20, ok);
      @(posedge clk); #1; req = 2'b00;
      wait_sig(1, 200, ok);
      n_tests++;
      if (!ok || done !== 2'b01) begin
         n_fail++; $display("FAIL to_next: got done=%b, expected 01", done);
      end
      @(negedge clk);
      n_tests++;
      if (rd_data !== 16'h5A5A) begin
         n_fail++; $display("FAIL to_next_rd: got %h, expected 5a5a", rd_data);
      end
   endtask

   task automatic test_drop();
      bit ok; int g1;
      repeat (4) @(posedge clk); #1; req = 2'b01;
      wait_sig(0, 20, ok);
      g1 = gnt1_cnt;
      @(posedge clk); #1; req = 2'b00;
      repeat (10) @(posedge clk); #1; req = 2'b10;
      repeat (10) @(posedge clk); #1; req = 2'b00;
      wait_sig(1, 200, ok);
      n_tests++;
      if (!ok || done !== 2'b01) begin
         n_fail++; $display("FAIL drop_done: got %b, expected 01", done);
      end
      repeat (4) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || gnt1_cnt != g1) begin
         n_fail++; $display("FAIL drop_nognt: got busy=%b gnt1=%0d, expected 0 0", busy, gnt1_cnt - g1);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      @(posedge clk); #1; req = 2'b10;
      wait_sig(0, 20, ok);
      @(posedge clk); #1; req = 2'b00;
      repeat (6) @(posedge clk); #1; rst = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || ss_n !== 2'b11 || gnt !== 2'b00) begin
         n_fail++; $display("FAIL rstmid_state: got busy=%b ss_n=%b gnt=%b, expected 0 11 00", busy, ss_n, gnt);
      end
      @(posedge clk); #1; rst = 1'b0; force_done = 1'b1;
      @(negedge clk);
      n_tests++;
      if (done !== 2'b00 || err !== 2'b00) begin
         n_fail++; $display("FAIL rstmid_stale: got done=%b err=%b, expected 00 00", done, err);
      end
      @(posedge clk); #1; force_done = 1'b0; req = 2'b11;
      @(negedge clk);
      n_tests++;
      if (gnt !== 2'b01) begin
         n_fail++; $display("FAIL rstmid_ptr: got gnt=%b, expected 01", gnt);
      end
      @(posedge clk); #1; req = 2'b00;
      wait_sig(1, 200, ok);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_idle_done();
      @(posedge clk); #1; model_rd = 16'hBEEF; force_done = 1'b1;
      @(negedge clk);
      n_tests++;
      if (done !== 2'b00 || err !== 2'b00 || busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_done: got done=%b err=%b busy=%b, expected 00 00 0", done, err, busy);
      end
      @(posedge clk); #1; force_done = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rd_data !== 16'h5A5A) begin
         n_fail++; $display("FAIL idle_rd: got %h, expected 5a5a", rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_timeout();
      test_drop();
      test_reset_mid();
      test_idle_done();
      n_tests++;
      if (both_low_cnt != 0) begin
         n_fail++; $display("FAIL ss_exclusive: got %0d cycles with both low, expected 0", both_low_cnt);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_spi_arb
